// File: rtl/fir_filter_param.sv
// Parametrised direct-form FIR filter with a load-gated coefficient bank, a
// two-stage multiply/accumulate pipeline, optional output saturation and flush.
module fir_filter_param #(
  parameter int WIDTH = 10,
  parameter int NTAPS = 9,
  parameter bit SAT   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   vin,
  input  logic [NTAPS*WIDTH-1:0] b,
  input  logic                   b_load,
  input  logic                   flush,
  output logic [WIDTH-1:0]       dout,
  output logic                   vout
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + $clog2(NTAPS);

  // Output range expressed at accumulator width so the clamp compares signed values.
  localparam logic signed [AW-1:0] MAX_V = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

  logic signed [WIDTH-1:0] x [NTAPS];
  logic signed [WIDTH-1:0] c [NTAPS];
  logic signed [PW-1:0]    p [NTAPS];
  logic                    v1;
  logic                    v2;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    acc_sh;
  logic [WIDTH-1:0]        dout_next;

  // Stage 0: delay line and coefficient bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these arrays are plain registers, not RAM, so they are reset;
      // no stale sample or coefficient may contribute to an output after reset.
      for (int k = 0; k < NTAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
      v1 <= 1'b0;
    end else begin
      if (b_load) begin
        for (int k = 0; k < NTAPS; k++) c[k] <= b[k*WIDTH +: WIDTH];
      end
      if (flush) begin
        for (int k = 0; k < NTAPS; k++) x[k] <= '0;
        v1 <= 1'b0;
      end else if (vin) begin
        // NOTE: non-blocking assignments make every tap read the pre-edge value,
        // which is what turns this loop into a shift register.
        x[0] <= din;
        for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
        v1 <= 1'b1;
      end else begin
        v1 <= 1'b0;
      end
    end
  end

  // Stage 1: one registered product per tap, using the coefficients in force before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) p[k] <= '0;
      v2 <= 1'b0;
    end else begin
      for (int k = 0; k < NTAPS; k++) p[k] <= PW'(x[k]) * PW'(c[k]);
      v2 <= v1 & ~flush;
    end
  end

  always_comb begin
    // NOTE: the accumulator starts from a default so every path assigns it (no latch),
    // and blocking assignments let each iteration see the previous partial sum.
    sum = '0;
    for (int k = 0; k < NTAPS; k++) sum = sum + AW'(p[k]);
  end

  // Arithmetic shift rounds toward -inf, matching the Q1.(WIDTH-1) product scaling.
  assign acc_sh = sum >>> (WIDTH - 1);

  always_comb begin
    dout_next = acc_sh[WIDTH-1:0];
    if (SAT) begin
      if (acc_sh > MAX_V)      dout_next = MAX_V[WIDTH-1:0];
      else if (acc_sh < MIN_V) dout_next = MIN_V[WIDTH-1:0];
    end
  end

  // Stage 2: output register; DOUT holds through bubbles and flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      vout <= 1'b0;
    end else if (flush) begin
      vout <= 1'b0;
    end else if (v2) begin
      dout <= dout_next;
      vout <= 1'b1;
    end else begin
      vout <= 1'b0;
    end
  end

endmodule
